// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register, 64-word ROM addressing and IF/ID pipeline register.
// Define JUMP_EARLY_EN to resolve J-type jumps in the fetch stage.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [5:0]  rom_addr,
  input  logic [31:0] rom_data,
  output logic        ifid_valid,
  output logic [31:0] ifid_instr,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4
);
  logic [31:0] pc_q, pc_d, pc4, seq_pc;
  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d, ipc_q, ipc_d, ipc4_q, ipc4_d;
  assign pc4 = pc_q + 32'd4;
`ifdef JUMP_EARLY_EN
  assign seq_pc = (rom_data[31:26] == 6'b000010) ? {pc4[31:28], rom_data[25:0], 2'b00} : pc4;
`else
  assign seq_pc = pc4;
`endif
  always_comb begin
    pc_d    = pc_q;
    valid_d = valid_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;
    ipc4_d  = ipc4_q;
    if (redirect) begin
      pc_d    = redirect_pc & ~32'h3;
      valid_d = 1'b0;
      instr_d = 32'h0;
      ipc_d   = 32'h0;
      ipc4_d  = 32'h0;
    end else if (!stall) begin
      pc_d    = seq_pc;
      valid_d = 1'b1;
      instr_d = rom_data;
      ipc_d   = pc_q;
      ipc4_d  = pc4;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= 32'h0;
      ipc_q   <= 32'h0;
      ipc4_q  <= 32'h0;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
      ipc4_q  <= ipc4_d;
    end
  end
  assign rom_addr   = pc_q[7:2];
  assign ifid_valid = valid_q;
  assign ifid_instr = instr_q;
  assign ifid_pc    = ipc_q;
  assign ifid_pc4   = ipc4_q;
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed checks of fetch, jump, stall, redirect, wrap and async reset.
module tb_instruction_fetch;
  logic        clk = 1'b0;
  logic        rst_n, stall, redirect;
  logic [31:0] redirect_pc, rom_data, ifid_instr, ifid_pc, ifid_pc4;
  logic [5:0]  rom_addr;
  logic        ifid_valid;
  logic [31:0] rom [64];
  int tests = 0;
  int fails = 0;

  instruction_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .rom_addr(rom_addr), .rom_data(rom_data),
    .ifid_valid(ifid_valid), .ifid_instr(ifid_instr), .ifid_pc(ifid_pc),
    .ifid_pc4(ifid_pc4)
  );

  always #5 clk = ~clk;
  assign rom_data = rom[rom_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_if(input string tag, input logic v, input logic [31:0] pc, input logic [31:0] ins);
    chk({tag, "_valid"}, {31'h0, ifid_valid}, {31'h0, v});
    chk({tag, "_pc"}, ifid_pc, pc);
    chk({tag, "_instr"}, ifid_instr, ins);
    chk({tag, "_pc4"}, ifid_pc4, v ? pc + 32'd4 : 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 | i;
    rom[0]  = 32'h0800000b;
    rom[1]  = 32'h20080042;
    rom[11] = 32'h14000001;
    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    #12;
    chk_if("reset", 1'b0, 32'h0, 32'h0);
    chk("reset_rom_addr", {26'h0, rom_addr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk_if("first", 1'b1, 32'h0, 32'h0800000b);
    cyc();
`ifdef JUMP_EARLY_EN
    chk_if("jump", 1'b1, 32'h2C, 32'h14000001);
`else
    chk_if("seq", 1'b1, 32'h4, 32'h20080042);
`endif
    redirect = 1'b1; redirect_pc = 32'h4;
    cyc();
    redirect = 1'b0;
    chk_if("flush", 1'b0, 32'h0, 32'h0);
    chk("redir_rom_addr", {26'h0, rom_addr}, 32'd1);
    cyc();
    chk_if("redir_fetch", 1'b1, 32'h4, 32'h20080042);
    chk("pre_stall_rom_addr", {26'h0, rom_addr}, 32'd2);
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("stall_rom_addr", {26'h0, rom_addr}, 32'd2);
      chk_if("stall_hold", 1'b1, 32'h4, 32'h20080042);
    end
    stall = 1'b0;
    cyc();
    chk_if("post_stall", 1'b1, 32'h8, rom[2]);
    chk("post_stall_rom_addr", {26'h0, rom_addr}, 32'd3);
    redirect = 1'b1; stall = 1'b1; redirect_pc = 32'h13;
    cyc();
    chk("rs_rom_addr", {26'h0, rom_addr}, 32'd4);
    chk_if("rs_flush", 1'b0, 32'h0, 32'h0);
    redirect = 1'b0; stall = 1'b0;
    cyc();
    chk_if("rs_fetch", 1'b1, 32'h10, rom[4]);
    redirect = 1'b1; redirect_pc = 32'hFC;
    cyc();
    redirect = 1'b0;
    chk("wrap_rom_addr63", {26'h0, rom_addr}, 32'd63);
    cyc();
    chk("wrap_rom_addr0", {26'h0, rom_addr}, 32'd0);
    chk_if("wrap", 1'b1, 32'hFC, rom[63]);
    chk("wrap_pc4", ifid_pc4, 32'h100);
    redirect = 1'b1; redirect_pc = 32'h20;
    cyc();
    redirect = 1'b0;
    cyc();
    chk("mid_rom_addr", {26'h0, rom_addr}, 32'd9);
    chk_if("mid_pre", 1'b1, 32'h20, rom[8]);
    #2 rst_n = 1'b0;
    #1;
    chk_if("mid_reset", 1'b0, 32'h0, 32'h0);
    chk("mid_reset_rom_addr", {26'h0, rom_addr}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    chk_if("after_reset", 1'b1, 32'h0, 32'h0800000b);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
